// File: rtl/shannon_cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shannon_cmp_pipe
//  Description : Two-stage Shannon-expanded add/compare. Stage A evaluates
//                both cofactors of "(in0 + in1) == in2, gated by en":
//                  late=0 cofactor : in0    + in1
//                  late=1 cofactor : CONST1 + in1
//                and registers the two results. Stage B uses the late select
//                only as a 2:1 mux select in front of the output flop.
//                A saturating counter tracks the number of out=1 results.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous active-high reset
//                in_valid   - operands valid this cycle
//                in0        - addend of the late=0 cofactor
//                in1        - common addend
//                in2        - compare target
//                en         - match enable, sampled with the operands
//                late       - late select, sampled one cycle after in_valid
//                clr        - synchronous clear of match_cnt
//                out        - selected compare result
//                out_valid  - out is valid this cycle
//                match_cnt  - saturating count of out=1 results
//  Revision    : 1.0 - initial pipelined, parametrised release
// ============================================================================
module shannon_cmp_pipe #(
    parameter int unsigned             WIDTH     = 8,
    parameter logic [WIDTH-1:0]        CONST1    = WIDTH'(1),
    parameter bit                      USE_CARRY = 1'b0,
    parameter int unsigned             CNT_W     = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  in_valid,
    input  wire logic [WIDTH-1:0]      in0,
    input  wire logic [WIDTH-1:0]      in1,
    input  wire logic [WIDTH-1:0]      in2,
    input  wire logic                  en,
    input  wire logic                  late,
    input  wire logic                  clr,
    output logic                       out,
    output logic                       out_valid,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Cofactor compare results, independent of late.
    logic w_eq0;
    logic w_eq1;

    generate
        if (USE_CARRY) begin : g_carry
            // One extra bit keeps the carry-out, so an overflowing sum can
            // never equal the zero-extended target.
            logic [WIDTH:0] w_s0;
            logic [WIDTH:0] w_s1;
            assign w_s0  = {1'b0, in0}    + {1'b0, in1};
            assign w_s1  = {1'b0, CONST1} + {1'b0, in1};
            assign w_eq0 = (w_s0 == {1'b0, in2});
            assign w_eq1 = (w_s1 == {1'b0, in2});
        end else begin : g_wrap
            // Sums wrap modulo 2^WIDTH.
            logic [WIDTH-1:0] w_s0;
            logic [WIDTH-1:0] w_s1;
            assign w_s0  = in0    + in1;
            assign w_s1  = CONST1 + in1;
            assign w_eq0 = (w_s0 == in2);
            assign w_eq1 = (w_s1 == in2);
        end
    endgenerate

    // Stage A registers.
    logic r_eq0;
    logic r_eq1;
    logic r_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eq0  <= 1'b0;
            r_eq1  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= in_valid;
            if (in_valid) begin
                r_eq0 <= w_eq0 & en;
                r_eq1 <= w_eq1 & en;
            end
        end
    end

    // Stage B: late drives nothing but this select, keeping its path to the
    // output flop a single mux level.
    logic w_sel;
    assign w_sel = late ? r_eq1 : r_eq0;

    logic             r_out;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_match_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_pend;
            if (r_pend) begin
                r_out <= w_sel;
            end
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_cnt <= '0;
        end else if (clr) begin
            r_match_cnt <= '0;
        end else if (r_pend && w_sel && (r_match_cnt != c_CNT_MAX)) begin
            r_match_cnt <= r_match_cnt + CNT_W'(1);
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign match_cnt = r_match_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shannon_cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shannon_cmp_pipe
//  Description : Scoreboard bench for shannon_cmp_pipe. Two instances share
//                one stimulus stream: dut0 wraps sums (USE_CARRY=0, 2-bit
//                counter), dut1 keeps the carry (USE_CARRY=1, 4-bit counter).
//                Expected results come from plain integer arithmetic.
//  Revision    : 1.0 - initial bench
// ============================================================================
module tb_shannon_cmp_pipe;

    typedef struct {
        int edge_n;
        int o;
    } res_t;

    typedef struct {
        int edge_n;
        int vld;
        int o;
        int cnt;
    } st_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in0 = '0;
    logic [7:0] in1 = '0;
    logic [7:0] in2 = '0;
    logic       en = 1'b0;
    logic       late = 1'b0;
    logic       clr = 1'b0;

    logic       out0, out_valid0;
    logic       out1, out_valid1;
    logic [1:0] match_cnt0;
    logic [3:0] match_cnt1;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    res_t rq[2][$];
    st_t  sq[2][$];

    // Reference state
    int m_pend = 0;
    int p_a = 0, p_b = 0, p_c = 0, p_e = 0;
    int m_out[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};
    int cnt_max[2] = '{3, 15};

    shannon_cmp_pipe #(.WIDTH(8), .USE_CARRY(1'b0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in0(in0), .in1(in1),
        .in2(in2), .en(en), .late(late), .clr(clr),
        .out(out0), .out_valid(out_valid0), .match_cnt(match_cnt0)
    );

    shannon_cmp_pipe #(.WIDTH(8), .USE_CARRY(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in0(in0), .in1(in1),
        .in2(in2), .en(en), .late(late), .clr(clr),
        .out(out1), .out_valid(out_valid1), .match_cnt(match_cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Integer model: selected addend plus in1, wrapped only in wrap mode.
    function automatic int exp_match(input int d, input int a, input int b,
                                     input int c, input int e, input int l);
        int s;
        s = (l != 0 ? 1 : a) + b;
        if (d == 0) s = s % 256;
        return (e != 0 && s == c) ? 1 : 0;
    endfunction

    // Drive one cycle of inputs and record what the next edge must produce.
    task automatic step(input int v, input int a, input int b, input int c,
                        input int e, input int l, input int cl, input int r);
        int ed;
        int o;
        int inc;
        st_t  s;
        res_t rr;
        @(negedge clk);
        in_valid = v[0];
        in0 = 8'(a);
        in1 = 8'(b);
        in2 = 8'(c);
        en = e[0];
        late = l[0];
        clr = cl[0];
        rst = r[0];
        ed = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (r != 0) begin
                m_out[d] = 0;
                m_cnt[d] = 0;
                s = '{edge_n: ed, vld: 0, o: 0, cnt: 0};
            end else begin
                inc = 0;
                if (m_pend != 0) begin
                    o = exp_match(d, p_a, p_b, p_c, p_e, l);
                    m_out[d] = o;
                    inc = o;
                    rr = '{edge_n: ed, o: o};
                    rq[d].push_back(rr);
                end
                if (cl != 0) m_cnt[d] = 0;
                else if (inc != 0 && m_cnt[d] < cnt_max[d]) m_cnt[d]++;
                s = '{edge_n: ed, vld: m_pend, o: m_out[d], cnt: m_cnt[d]};
            end
            sq[d].push_back(s);
        end
        if (r != 0) begin
            m_pend = 0;
        end else begin
            m_pend = v;
            if (v != 0) begin
                p_a = a; p_b = b; p_c = c; p_e = e;
            end
        end
    endtask

    // Monitor: compares every edge the driver described.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                int ov, o, cnt;
                st_t  s;
                res_t rr;
                ov  = (d == 0) ? int'(out_valid0) : int'(out_valid1);
                o   = (d == 0) ? int'(out0) : int'(out1);
                cnt = (d == 0) ? int'(match_cnt0) : int'(match_cnt1);
                if (sq[d].size() != 0 && sq[d][0].edge_n == cyc) begin
                    s = sq[d].pop_front();
                    check($sformatf("dut%0d match_cnt", d), cnt, s.cnt);
                    check($sformatf("dut%0d out_valid", d), ov, s.vld);
                    if (ov != 0) begin
                        if (rq[d].size() == 0) begin
                            check($sformatf("dut%0d unexpected result", d), 1, 0);
                        end else begin
                            rr = rq[d].pop_front();
                            check($sformatf("dut%0d result edge", d), cyc, rr.edge_n);
                            check($sformatf("dut%0d out", d), o, rr.o);
                        end
                    end else begin
                        check($sformatf("dut%0d out hold", d), o, s.o);
                    end
                end
            end
        end
    end

    initial begin
        int a, b, c, sel;
        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Basic match
        step(1, 3, 5, 8, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Late select on the same operands, then late toggled with nothing pending
        step(1, 0, 7, 8, 1, 0, 0, 0);
        step(1, 0, 7, 8, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Enable low
        step(1, 2, 2, 4, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Wrap vs carry
        step(1, 200, 100, 44, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Stream and saturation, then clear against a matching result
        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 3, 5, 8, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 5, 8, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-flight, then basic match again
        step(1, 3, 5, 8, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 5, 8, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic with matches biased in
        for (int i = 0; i < 600; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: c = int'($urandom_range(0, 255));
                1: c = (a + b) % 256;
                2: c = (1 + b) % 256;
                default: c = (a < 128) ? (a + b) % 256 : (1 + b) % 256;
            endcase
            step(($urandom_range(0, 9) < 8) ? 1 : 0, a, b, c,
                 ($urandom_range(0, 7) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0) ? 1 : 0,
                 ($urandom_range(0, 63) == 0) ? 1 : 0);
        end

        // Drain
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d results left undelivered", d), rq[d].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
